// File: rtl/Noc_parameters.sv
// Noc_parameters: shared NoC sizing and the flit payload layout.
// Flit = {is_header, is_tail, data}; Noc_Flit_Width = Noc_Data_Width + 2.
package Noc_parameters;

  localparam int unsigned Noc_VC_Channel = 4;
  localparam int unsigned Noc_Data_Width = 16;
  localparam int unsigned Noc_Flit_Width = Noc_Data_Width + 2;

  typedef struct packed {
    logic                      is_header;
    logic                      is_tail;
    logic [Noc_Data_Width-1:0] data;
  } noc_flit_t;

endpackage

// File: rtl/noc_vc_inject_arbiter_pkg.sv
// noc_vc_inject_arbiter_pkg: derived widths and flit bit positions for the injector.
package noc_vc_inject_arbiter_pkg;
  import Noc_parameters::*;

  localparam int unsigned VC_IDX_W      = (Noc_VC_Channel > 1) ? $clog2(Noc_VC_Channel) : 1;
  localparam int unsigned FLIT_HDR_BIT  = Noc_Flit_Width - 1;
  localparam int unsigned FLIT_TAIL_BIT = Noc_Flit_Width - 2;

endpackage

// File: rtl/Noc_flit_interface.sv
// Noc_flit_interface: per-VC valid/flit from sender to receiver, per-VC ready back.
//   sender   : drives valid, flit; samples ready
//   receiver : samples valid, flit; drives ready
interface Noc_flit_interface;
  import Noc_parameters::*;

  logic [Noc_VC_Channel-1:0]                     valid;
  logic [Noc_VC_Channel-1:0]                     ready;
  logic [Noc_VC_Channel-1:0][Noc_Flit_Width-1:0] flit;

  modport sender   (output valid, output flit, input ready);
  modport receiver (input valid, input flit, output ready);

endinterface

// File: rtl/noc_rr_arbiter.sv
// noc_rr_arbiter: round-robin arbiter; search starts at ptr, ptr moves past
// the winner only when advance is asserted.
//   noc_clk, noc_rst : clock, async active-high reset
//   req              : request vector
//   advance          : commit the current grant (update pointer)
//   grant_c          : one-hot grant (combinational)
//   grant_idx_c      : index of the granted requester (combinational)
//   grant_valid_c    : some request is granted (combinational)
module noc_rr_arbiter #(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic             noc_clk,
  input  logic             noc_rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant_c,
  output logic [IDX_W-1:0] grant_idx_c,
  output logic             grant_valid_c
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_nxt;

  // First requester at or after ptr, wrapping modulo N.
  always_comb begin
    int unsigned      sum;
    logic [IDX_W-1:0] cand;
    grant_c       = '0;
    grant_idx_c   = '0;
    grant_valid_c = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      sum  = 32'(ptr) + k;
      cand = IDX_W'(sum % N);
      if (!grant_valid_c && req[cand]) begin
        grant_valid_c  = 1'b1;
        grant_idx_c    = cand;
        grant_c[cand]  = 1'b1;
      end
    end
  end

  assign ptr_nxt = (grant_idx_c == IDX_W'(N - 1)) ? '0 : grant_idx_c + IDX_W'(1);

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      ptr <= '0;
    end else if (advance && grant_valid_c) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/noc_vc_inject_arbiter.sv
// noc_vc_inject_arbiter: shares one NoC sender port among NUM_REQ flit sources,
// binding each packet to a free VC (round-robin over requesters, lowest free VC)
// until its tail flit is accepted.
//   noc_clk, noc_rst : clock, async active-high reset
//   req_valid/flit   : per-requester flit offer
//   req_ready        : per-requester accept (combinational from sender ready)
//   req_vc           : VC bound to each requester (valid while bound)
//   noc_sender_if    : registered per-VC valid/flit out, ready in
//   vc_busy          : VC bound to some requester
//   protocol_err     : sticky; unbound requester offered a non-header flit
module noc_vc_inject_arbiter
  import Noc_parameters::*;
  import noc_vc_inject_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_REQ   = 4,
  localparam int unsigned REQ_IDX_W = $clog2(NUM_REQ)
) (
  input  logic                                    noc_clk,
  input  logic                                    noc_rst,
  input  logic [NUM_REQ-1:0]                      req_valid,
  input  logic [NUM_REQ-1:0][Noc_Flit_Width-1:0]  req_flit,
  output logic [NUM_REQ-1:0]                      req_ready,
  output logic [NUM_REQ-1:0][VC_IDX_W-1:0]        req_vc,
  Noc_flit_interface.sender                       noc_sender_if,
  output logic [Noc_VC_Channel-1:0]               vc_busy,
  output logic                                    protocol_err
);

  logic [NUM_REQ-1:0]                            bound, bound_nxt;
  logic [NUM_REQ-1:0]                            eligible, xfer, hdr_err;
  logic [NUM_REQ-1:0][VC_IDX_W-1:0]              req_vc_nxt;
  logic [Noc_VC_Channel-1:0][REQ_IDX_W-1:0]      vc_owner, owner_nxt;
  logic [Noc_VC_Channel-1:0]                     busy_nxt, out_valid_nxt;
  logic [Noc_VC_Channel-1:0][Noc_Flit_Width-1:0] out_flit_nxt;
  logic                                          free_found;
  logic [VC_IDX_W-1:0]                           free_vc;
  logic [NUM_REQ-1:0]                            gnt_onehot;
  logic [REQ_IDX_W-1:0]                          gnt_idx;
  logic                                          gnt_valid;
  logic                                          alloc;

  // Per-requester eligibility, handshake and header-protocol check.
  always_comb begin
    eligible  = '0;
    req_ready = '0;
    xfer      = '0;
    hdr_err   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      eligible[i]  = !bound[i] && req_valid[i] && req_flit[i][FLIT_HDR_BIT];
      req_ready[i] = bound[i] && noc_sender_if.ready[req_vc[i]];
      xfer[i]      = req_valid[i] && req_ready[i];
      hdr_err[i]   = !bound[i] && req_valid[i] && !req_flit[i][FLIT_HDR_BIT];
    end
  end

  // Lowest-index free VC; uses registered busy so a VC freed this cycle waits a cycle.
  always_comb begin
    free_found = 1'b0;
    free_vc    = '0;
    for (int unsigned v = 0; v < Noc_VC_Channel; v++) begin
      if (!free_found && !vc_busy[v]) begin
        free_found = 1'b1;
        free_vc    = VC_IDX_W'(v);
      end
    end
  end

  // Pointer only advances on an actual allocation, so it holds while all VCs are busy.
  assign alloc = gnt_valid && free_found;

  noc_rr_arbiter #(.N(NUM_REQ)) u_rr (
    .noc_clk       (noc_clk),
    .noc_rst       (noc_rst),
    .req           (eligible),
    .advance       (alloc),
    .grant_c       (gnt_onehot),
    .grant_idx_c   (gnt_idx),
    .grant_valid_c (gnt_valid)
  );

  // Binding tables: release on tail transfer, then at most one new binding.
  always_comb begin
    bound_nxt  = bound;
    req_vc_nxt = req_vc;
    busy_nxt   = vc_busy;
    owner_nxt  = vc_owner;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (xfer[i] && req_flit[i][FLIT_TAIL_BIT]) begin
        bound_nxt[i]        = 1'b0;
        busy_nxt[req_vc[i]] = 1'b0;
      end
    end
    if (alloc) begin
      bound_nxt           = bound_nxt | gnt_onehot;
      req_vc_nxt[gnt_idx] = free_vc;
      busy_nxt[free_vc]   = 1'b1;
      owner_nxt[free_vc]  = gnt_idx;
    end
  end

  // Forwarding mux: each busy VC takes its owner's flit when the owner transfers.
  always_comb begin
    out_valid_nxt = '0;
    out_flit_nxt  = '0;
    for (int unsigned v = 0; v < Noc_VC_Channel; v++) begin
      out_valid_nxt[v] = vc_busy[v] && xfer[vc_owner[v]];
      if (out_valid_nxt[v]) begin
        out_flit_nxt[v] = req_flit[vc_owner[v]];
      end
    end
  end

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      bound               <= '0;
      req_vc              <= '0;
      vc_busy             <= '0;
      vc_owner            <= '0;
      protocol_err        <= 1'b0;
      noc_sender_if.valid <= '0;
      noc_sender_if.flit  <= '0;
    end else begin
      bound               <= bound_nxt;
      req_vc              <= req_vc_nxt;
      vc_busy             <= busy_nxt;
      vc_owner            <= owner_nxt;
      protocol_err        <= protocol_err | (|hdr_err);
      noc_sender_if.valid <= out_valid_nxt;
      noc_sender_if.flit  <= out_flit_nxt;
    end
  end

endmodule

// File: tb/tb_noc_vc_inject_arbiter.sv
// tb_noc_vc_inject_arbiter: directed bench for noc_vc_inject_arbiter with 5 requesters, 4 VCs.
module tb_noc_vc_inject_arbiter;
  import Noc_parameters::*;

  localparam int unsigned NR = 5;
  localparam int unsigned VW = 2;
  localparam int unsigned FW = Noc_Flit_Width;

  logic                   noc_clk = 1'b0;
  logic                   noc_rst;
  logic [NR-1:0]          req_valid;
  logic [NR-1:0][FW-1:0]  req_flit;
  logic [NR-1:0]          req_ready;
  logic [NR-1:0][VW-1:0]  req_vc;
  logic [3:0]             vc_busy;
  logic                   protocol_err;

  Noc_flit_interface nif();

  noc_vc_inject_arbiter #(.NUM_REQ(NR)) dut (
    .noc_clk       (noc_clk),
    .noc_rst       (noc_rst),
    .req_valid     (req_valid),
    .req_flit      (req_flit),
    .req_ready     (req_ready),
    .req_vc        (req_vc),
    .noc_sender_if (nif),
    .vc_busy       (vc_busy),
    .protocol_err  (protocol_err)
  );

  always #5 noc_clk = ~noc_clk;

  int checks = 0;
  int errors = 0;

  // Packet driver state: requester i sends pkt_len[i] flits, data = pkt_base[i] + k.
  bit          pkt_act  [NR];
  int unsigned pkt_len  [NR];
  int unsigned pkt_idx  [NR];
  logic [15:0] pkt_base [NR];

  function automatic logic [FW-1:0] mk_flit(bit h, bit t, logic [15:0] d);
    noc_flit_t f;
    f.is_header = h;
    f.is_tail   = t;
    f.data      = d;
    return f;
  endfunction

  task automatic present();
    for (int i = 0; i < NR; i++) begin
      if (pkt_act[i] && pkt_idx[i] < pkt_len[i]) begin
        req_valid[i] = 1'b1;
        req_flit[i]  = mk_flit(pkt_idx[i] == 0, pkt_idx[i] == pkt_len[i] - 1,
                               pkt_base[i] + 16'(pkt_idx[i]));
      end else begin
        req_valid[i] = 1'b0;
        req_flit[i]  = '0;
      end
    end
  endtask

  task automatic start_pkt(int i, int unsigned len, logic [15:0] base);
    pkt_act[i]  = 1'b1;
    pkt_len[i]  = len;
    pkt_idx[i]  = 0;
    pkt_base[i] = base;
  endtask

  task automatic clear_pkts();
    for (int i = 0; i < NR; i++) begin
      pkt_act[i] = 1'b0;
      pkt_idx[i] = 0;
      pkt_len[i] = 0;
    end
    present();
  endtask

  // Record transfers, clock one edge, step each packet, re-present; ends at posedge+2.
  task automatic advance();
    logic [NR-1:0] x;
    x = req_valid & req_ready;
    @(posedge noc_clk);
    #1;
    for (int i = 0; i < NR; i++) if (x[i]) pkt_idx[i]++;
    present();
    #1;
  endtask

  task automatic reset_dut();
    noc_rst   = 1'b1;
    nif.ready = '1;
    clear_pkts();
    @(negedge noc_clk);
    noc_rst = 1'b0;
    @(posedge noc_clk);
    #1;
  endtask

  task automatic test_reset();
    noc_rst   = 1'b1;
    nif.ready = '1;
    clear_pkts();
    #2;
    checks++; if (nif.valid !== 4'b0) begin errors++; $display("FAIL reset_valid: got %0h expected 0", nif.valid); end
    checks++; if (nif.flit !== '0) begin errors++; $display("FAIL reset_flit: got %0h expected 0", nif.flit); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %0h expected 0", req_ready); end
    checks++; if (req_vc !== '0) begin errors++; $display("FAIL reset_req_vc: got %0h expected 0", req_vc); end
    checks++; if (vc_busy !== 4'b0) begin errors++; $display("FAIL reset_vc_busy: got %0h expected 0", vc_busy); end
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL reset_protocol_err: got %0b expected 0", protocol_err); end
    @(negedge noc_clk);
    noc_rst = 1'b0;
    @(posedge noc_clk);
    #1;
  endtask

  task automatic test_single_packet();
    start_pkt(0, 3, 16'h0100);
    present();
    #1;
    checks++; if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL single_c0_ready: got %0b expected 0", req_ready[0]); end
    checks++; if (vc_busy !== 4'b0000) begin errors++; $display("FAIL single_c0_busy: got %0h expected 0", vc_busy); end
    advance();
    checks++; if (vc_busy !== 4'b0001) begin errors++; $display("FAIL single_c1_busy: got %0h expected 1", vc_busy); end
    checks++; if (req_vc[0] !== 2'd0) begin errors++; $display("FAIL single_c1_vc: got %0d expected 0", req_vc[0]); end
    checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL single_c1_ready: got %0b expected 1", req_ready[0]); end
    advance();
    checks++; if (nif.valid !== 4'b0001) begin errors++; $display("FAIL single_c2_valid: got %0h expected 1", nif.valid); end
    checks++; if (nif.flit[0] !== mk_flit(1, 0, 16'h0100)) begin errors++; $display("FAIL single_c2_flit: got %0h expected %0h", nif.flit[0], mk_flit(1, 0, 16'h0100)); end
    advance();
    checks++; if (nif.flit[0] !== mk_flit(0, 0, 16'h0101)) begin errors++; $display("FAIL single_c3_flit: got %0h expected %0h", nif.flit[0], mk_flit(0, 0, 16'h0101)); end
    checks++; if (vc_busy !== 4'b0001) begin errors++; $display("FAIL single_c3_busy: got %0h expected 1", vc_busy); end
    advance();
    checks++; if (nif.flit[0] !== mk_flit(0, 1, 16'h0102)) begin errors++; $display("FAIL single_c4_flit: got %0h expected %0h", nif.flit[0], mk_flit(0, 1, 16'h0102)); end
    checks++; if (vc_busy !== 4'b0000) begin errors++; $display("FAIL single_c4_busy: got %0h expected 0", vc_busy); end
    advance();
    checks++; if (nif.valid !== 4'b0000) begin errors++; $display("FAIL single_c5_valid: got %0h expected 0", nif.valid); end
  endtask

  task automatic test_round_robin();
    logic [3:0]    exp_busy [10];
    logic [3:0]    exp_vld  [10];
    logic [FW-1:0] ef;
    int            k;
    exp_busy = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h0};
    exp_vld  = '{4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
    reset_dut();
    for (int i = 0; i < 4; i++) start_pkt(i, 4, 16'h0200 + 16'(i * 16));
    present();
    #1;
    for (int c = 0; c < 10; c++) begin
      checks++; if (vc_busy !== exp_busy[c]) begin errors++; $display("FAIL rr_busy c%0d: got %0h expected %0h", c, vc_busy, exp_busy[c]); end
      checks++; if (nif.valid !== exp_vld[c]) begin errors++; $display("FAIL rr_valid c%0d: got %0h expected %0h", c, nif.valid, exp_vld[c]); end
      for (int v = 0; v < 4; v++) begin
        k  = c - v - 2;
        ef = (k >= 0 && k <= 3) ? mk_flit(k == 0, k == 3, 16'h0200 + 16'(v * 16 + k)) : '0;
        checks++; if (nif.flit[v] !== ef) begin errors++; $display("FAIL rr_flit c%0d vc%0d: got %0h expected %0h", c, v, nif.flit[v], ef); end
      end
      if (c == 4) begin
        for (int i = 0; i < 4; i++) begin
          checks++; if (req_vc[i] !== VW'(i)) begin errors++; $display("FAIL rr_req_vc r%0d: got %0d expected %0d", i, req_vc[i], i); end
        end
      end
      advance();
    end
  endtask

  task automatic test_vc_exhaustion();
    reset_dut();
    start_pkt(0, 5, 16'h0300);
    start_pkt(1, 6, 16'h0310);
    start_pkt(2, 6, 16'h0320);
    start_pkt(3, 6, 16'h0330);
    start_pkt(4, 2, 16'h0340);
    present();
    #1;
    for (int c = 0; c < 12; c++) begin
      if (c >= 4 && c <= 6) begin
        checks++; if (req_ready[4] !== 1'b0) begin errors++; $display("FAIL exh_wait_ready c%0d: got %0b expected 0", c, req_ready[4]); end
      end
      if (c == 4 || c == 5) begin
        checks++; if (vc_busy !== 4'hF) begin errors++; $display("FAIL exh_full c%0d: got %0h expected f", c, vc_busy); end
      end
      if (c == 6) begin
        checks++; if (vc_busy !== 4'hE) begin errors++; $display("FAIL exh_release c6: got %0h expected e", vc_busy); end
      end
      if (c == 7) begin
        checks++; if (vc_busy !== 4'hF) begin errors++; $display("FAIL exh_rebind_busy: got %0h expected f", vc_busy); end
        checks++; if (req_vc[4] !== 2'd0) begin errors++; $display("FAIL exh_rebind_vc: got %0d expected 0", req_vc[4]); end
        checks++; if (req_ready[4] !== 1'b1) begin errors++; $display("FAIL exh_rebind_ready: got %0b expected 1", req_ready[4]); end
      end
      if (c == 8) begin
        checks++; if (nif.flit[0] !== mk_flit(1, 0, 16'h0340)) begin errors++; $display("FAIL exh_hdr_out: got %0h expected %0h", nif.flit[0], mk_flit(1, 0, 16'h0340)); end
      end
      if (c == 9) begin
        checks++; if (nif.flit[0] !== mk_flit(0, 1, 16'h0341)) begin errors++; $display("FAIL exh_tail_out: got %0h expected %0h", nif.flit[0], mk_flit(0, 1, 16'h0341)); end
      end
      if (c == 11) begin
        checks++; if (vc_busy !== 4'h0) begin errors++; $display("FAIL exh_drain: got %0h expected 0", vc_busy); end
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    logic [11:0]   exp_v;
    logic [11:0]   exp_r;
    logic [FW-1:0] got [$];
    logic [FW-1:0] ef;
    exp_v = 12'h78C;
    exp_r = 12'h3C6;
    reset_dut();
    start_pkt(0, 6, 16'h0400);
    present();
    for (int c = 0; c < 12; c++) begin
      nif.ready[0] = !(c >= 3 && c <= 5);
      #1;
      checks++; if (req_ready[0] !== exp_r[c]) begin errors++; $display("FAIL bp_ready c%0d: got %0b expected %0b", c, req_ready[0], exp_r[c]); end
      checks++; if (nif.valid[0] !== exp_v[c]) begin errors++; $display("FAIL bp_valid c%0d: got %0b expected %0b", c, nif.valid[0], exp_v[c]); end
      if (nif.valid[0] === 1'b1) got.push_back(nif.flit[0]);
      advance();
    end
    nif.ready = '1;
    checks++; if (got.size() != 6) begin errors++; $display("FAIL bp_count: got %0d expected 6", got.size()); end
    for (int k = 0; k < 6 && k < got.size(); k++) begin
      ef = mk_flit(k == 0, k == 5, 16'h0400 + 16'(k));
      checks++; if (got[k] !== ef) begin errors++; $display("FAIL bp_seq k%0d: got %0h expected %0h", k, got[k], ef); end
    end
  endtask

  task automatic test_single_flit_err();
    reset_dut();
    start_pkt(1, 1, 16'h0500);
    present();
    #1;
    checks++; if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL sf_c0_ready: got %0b expected 0", req_ready[1]); end
    advance();
    checks++; if (vc_busy !== 4'b0001) begin errors++; $display("FAIL sf_c1_busy: got %0h expected 1", vc_busy); end
    checks++; if (req_vc[1] !== 2'd0) begin errors++; $display("FAIL sf_c1_vc: got %0d expected 0", req_vc[1]); end
    checks++; if (req_ready[1] !== 1'b1) begin errors++; $display("FAIL sf_c1_ready: got %0b expected 1", req_ready[1]); end
    advance();
    checks++; if (vc_busy !== 4'b0000) begin errors++; $display("FAIL sf_c2_busy: got %0h expected 0", vc_busy); end
    checks++; if (nif.valid !== 4'b0001) begin errors++; $display("FAIL sf_c2_valid: got %0h expected 1", nif.valid); end
    checks++; if (nif.flit[0] !== mk_flit(1, 1, 16'h0500)) begin errors++; $display("FAIL sf_c2_flit: got %0h expected %0h", nif.flit[0], mk_flit(1, 1, 16'h0500)); end
    clear_pkts();
    req_valid[2] = 1'b1;
    req_flit[2]  = mk_flit(0, 0, 16'h0555);
    #1;
    checks++; if (req_ready[2] !== 1'b0) begin errors++; $display("FAIL err_ready: got %0b expected 0", req_ready[2]); end
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL err_early: got %0b expected 0", protocol_err); end
    @(posedge noc_clk);
    #1;
    checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL err_set: got %0b expected 1", protocol_err); end
    checks++; if (req_ready[2] !== 1'b0) begin errors++; $display("FAIL err_ready2: got %0b expected 0", req_ready[2]); end
    checks++; if (vc_busy !== 4'b0000) begin errors++; $display("FAIL err_no_bind: got %0h expected 0", vc_busy); end
    req_valid[2] = 1'b0;
    req_flit[2]  = '0;
    repeat (3) @(posedge noc_clk);
    #1;
    checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0b expected 1", protocol_err); end
  endtask

  task automatic test_reset_mid();
    start_pkt(0, 6, 16'h0600);
    start_pkt(1, 6, 16'h0610);
    present();
    #1;
    repeat (3) advance();
    checks++; if (vc_busy !== 4'b0011) begin errors++; $display("FAIL rm_pre_busy: got %0h expected 3", vc_busy); end
    checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL rm_pre_err: got %0b expected 1", protocol_err); end
    #2;
    noc_rst = 1'b1;
    #1;
    checks++; if (nif.valid !== 4'b0) begin errors++; $display("FAIL rm_valid: got %0h expected 0", nif.valid); end
    checks++; if (nif.flit !== '0) begin errors++; $display("FAIL rm_flit: got %0h expected 0", nif.flit); end
    checks++; if (vc_busy !== 4'b0) begin errors++; $display("FAIL rm_busy: got %0h expected 0", vc_busy); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL rm_ready: got %0h expected 0", req_ready); end
    checks++; if (req_vc !== '0) begin errors++; $display("FAIL rm_vc: got %0h expected 0", req_vc); end
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL rm_err: got %0b expected 0", protocol_err); end
    clear_pkts();
    @(negedge noc_clk);
    noc_rst = 1'b0;
    @(posedge noc_clk);
    #1;
    start_pkt(1, 2, 16'h0620);
    start_pkt(3, 2, 16'h0630);
    present();
    #1;
    advance();
    checks++; if (vc_busy !== 4'b0001) begin errors++; $display("FAIL rm_c1_busy: got %0h expected 1", vc_busy); end
    checks++; if (req_vc[1] !== 2'd0) begin errors++; $display("FAIL rm_c1_vc: got %0d expected 0", req_vc[1]); end
    checks++; if (req_ready[1] !== 1'b1) begin errors++; $display("FAIL rm_c1_ready1: got %0b expected 1", req_ready[1]); end
    checks++; if (req_ready[3] !== 1'b0) begin errors++; $display("FAIL rm_c1_ready3: got %0b expected 0", req_ready[3]); end
    advance();
    checks++; if (vc_busy !== 4'b0011) begin errors++; $display("FAIL rm_c2_busy: got %0h expected 3", vc_busy); end
    checks++; if (req_vc[3] !== 2'd1) begin errors++; $display("FAIL rm_c2_vc: got %0d expected 1", req_vc[3]); end
    clear_pkts();
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_vc_exhaustion();
    test_backpressure();
    test_single_flit_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/noc_vc_inject_arbiter.md
# noc_vc_inject_arbiter

Shares one `Noc_flit_interface.sender` port among `NUM_REQ` local flit sources, such as test nodes or NI packetizers, and allocates the port's virtual channels at packet granularity. A requester presenting a header flit is bound to a free VC by round-robin arbitration. Its flits are then forwarded on that VC until its tail flit is accepted, and the VC is released. The block sits between the local packet sources and the router's local input port.

## Interface
- `NUM_REQ`, default 4: number of requesters (≥2).
- `Noc_VC_Channel`, from `Noc_parameters`: VC count of the output port.
- `Noc_Flit_Width`, from `Noc_parameters`, equals `Noc_Data_Width+2`: flit = {is_header, is_tail, data}.
- `noc_clk`  in  1  the single clock.
- `noc_rst`  in  1  reset, asynchronous and active-high.
- `req_valid`  in  NUM_REQ  the requester presents a flit.
- `req_flit`  in  NUM_REQ×Noc_Flit_Width  flit per requester.
- `req_ready`  out  NUM_REQ  the flit is accepted this cycle (transfer = valid & ready).
- `req_vc`  out  NUM_REQ×$clog2(Noc_VC_Channel)  the VC bound to each requester; meaningful only while bound.
- `noc_sender_if`  sender modport  —  drives `valid[VC]` and `flit[VC]`; samples `ready[VC]`.
- `vc_busy`  out  Noc_VC_Channel  the VC is bound to a requester.
- `protocol_err`  out  1  sticky; set when an unbound requester presents a non-header flit.

## Operation
**Per-requester state.** Each requester is either `UNBOUND` or `BOUND(vc)`. Each VC is either `FREE` or `BUSY(req)`.

**Allocation.**
- A requester is eligible when it is `UNBOUND`, `req_valid=1`, and `is_header=1`.
- At most one allocation happens per cycle.
- The target VC is the lowest-index `FREE` VC.
- The winner is chosen round-robin starting at pointer `rr_ptr`. After a grant, `rr_ptr` becomes `grant+1` mod `NUM_REQ`.
- The binding is registered. The header is not consumed in the allocation cycle.

**Forwarding.**
- `req_ready[i] = BOUND(vc) && noc_sender_if.ready[vc]`, combinational.
- On a transfer, on the next edge: `valid[vc]<=1` and `flit[vc]<=req_flit[i]`.
- In any cycle without a transfer on a VC: `valid[vc]<=0` and `flit[vc]<=0`.

**Release.**
- When a flit with `is_tail=1` transfers, the requester returns to `UNBOUND` and the VC to `FREE` at the same edge.
- The released VC is not re-allocated in the cycle the tail transfers. It becomes eligible from the next cycle.
- A single-flit packet (header and tail both set) binds, transfers once, and releases.

**Errors.** An `UNBOUND` requester presenting a non-header flit gets `req_ready=0` and sets `protocol_err`. The error clears only on reset.

**Boundary behaviour.**
- All VCs busy: eligible headers wait, and `rr_ptr` is held.
- `ready[vc]` drops mid-packet: the requester stalls and a bubble appears on the VC. No flit is lost or duplicated.
- Reset mid-packet: all bindings are dropped and the partial packet is abandoned. Downstream recovery is outside this block.

## Timing
**Reset values.**
- `noc_sender_if.valid=0`, `flit[*]=0`
- `req_ready=0`, `req_vc=0`, `vc_busy=0`, `protocol_err=0`
- `rr_ptr=0`

**Cycle-level behaviour.**
- Header latency: allocation at cycle T, header transfer at T+1 if `ready` is high, output valid at T+2.
- Steady state: one flit per cycle per VC. Different VCs proceed concurrently.
- Flit latency from transfer to `noc_sender_if`: 1 cycle, registered.
- A requester's throughput is bounded only by `ready` of its bound VC.

## Structure
- Add `Noc_Flit_Width` and a `noc_flit_t` packed struct {is_header, is_tail, data} to `Noc_parameters`.
- Sub-module `noc_rr_arbiter`:
  - Parameter `N`.
  - Inputs: one-hot-capable request vector, advance enable.
  - Outputs: one-hot grant and grant index.
  - Owns the pointer.
- Top level: binding table (requester→VC, VC→requester), forwarding mux, output registers.

## Test plan
- **Single requester.** Req0 sends a 3-flit packet, all VCs ready.
  - Required: bind to VC0, outputs at cycles T+2..T+4 with the correct H/T bits, `vc_busy[0]` clears after the tail.
- **Round-robin.** Req0–req3 present headers simultaneously, `Noc_VC_Channel=4`.
  - Required: grants in order 0,1,2,3 on successive cycles to VC0,1,2,3; all four packets stream concurrently.
- **VC exhaustion.** Five requesters (`NUM_REQ=5`), 4 VCs.
  - Required: req4 waits until the first tail releases VCk, is bound to VCk the cycle after, and never earlier.
- **Backpressure.** Deassert `ready[0]` for 3 cycles mid-packet.
  - Required: `req_ready[0]=0` and `valid[0]=0` during the stall; the data sequence resumes intact with no duplicates.
- **Single-flit packet and protocol error.** Req1 sends a header+tail flit, then unbound req2 presents a data flit.
  - Required: req1 binds and releases in 2 cycles; `protocol_err=1` stays sticky; `req_ready[2]=0`.
- **Reset mid-packet.** Assert `noc_rst` asynchronously mid-packet.
  - Required: all outputs return to their reset values immediately, and the next header is re-allocated from VC0 with `rr_ptr=0`.
